// File: rtl/mux_estrutural.sv
// 4:1 multiplexer built from NOT/AND/OR gate primitives, one slice per data bit,
// followed by a single output register with synchronous active-high reset.
module mux_estrutural #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] D0,
   input  logic [WIDTH-1:0] D1,
   input  logic [WIDTH-1:0] D2,
   input  logic [WIDTH-1:0] D3,
   input  logic             S0,
   input  logic             S1,
   output logic [WIDTH-1:0] Y
);

   wire             s0_n;
   wire             s1_n;
   wire [WIDTH-1:0] m;

   // Select inversions are shared by every bit slice
   not u_not_s0 (s0_n, S0);
   not u_not_s1 (s1_n, S1);

   // Per-bit sum of products; an unselected data bit always meets a 0 in its AND
   for (genvar i = 0; i < int'(WIDTH); i++) begin : g_slice
      wire p0;
      wire p1;
      wire p2;
      wire p3;

      and u_and0 (p0, D0[i], s1_n, s0_n);
      and u_and1 (p1, D1[i], s1_n, S0);
      and u_and2 (p2, D2[i], S1,   s0_n);
      and u_and3 (p3, D3[i], S1,   S0);
      or  u_or   (m[i], p0, p1, p2, p3);
   end

   always_ff @(posedge clk) begin
      if (rst) Y <= '0;
      else     Y <= m;
   end

endmodule

// File: tb/tb_mux_estrutural.sv
// Scoreboard bench for mux_estrutural: a 1-bit and an 8-bit instance share clock,
// reset and select; expected outputs are queued at drive time and checked after each edge.
module tb_mux_estrutural;

   logic       clk;
   logic       rst;
   logic       s0;
   logic       s1;
   logic       d0_1, d1_1, d2_1, d3_1;
   logic [7:0] d0_8, d1_8, d2_8, d3_8;
   logic       y1;
   logic [7:0] y8;

   logic [8:0] exp_q[$];
   logic [8:0] exp;
   int         passed;
   int         total;

   mux_estrutural #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .D0(d0_1), .D1(d1_1), .D2(d2_1), .D3(d3_1),
      .S0(s0), .S1(s1), .Y(y1)
   );

   mux_estrutural #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst),
      .D0(d0_8), .D1(d1_8), .D2(d2_8), .D3(d3_8),
      .S0(s0), .S1(s1), .Y(y8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] model8(input logic r, input logic [1:0] s,
                                         input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c, input logic [7:0] d);
      if (r) return 8'h00;
      case (s)
         2'd0:    return a;
         2'd1:    return b;
         2'd2:    return c;
         default: return d;
      endcase
   endfunction

   // Drive one cycle of stimulus and queue what both outputs must show after the next edge
   task automatic apply(input logic r, input logic [1:0] s, input logic [3:0] b1,
                        input logic [7:0] a8, input logic [7:0] b8,
                        input logic [7:0] c8, input logic [7:0] e8);
      logic e1;
      rst  = r;
      {s1, s0} = s;
      d0_1 = b1[0]; d1_1 = b1[1]; d2_1 = b1[2]; d3_1 = b1[3];
      d0_8 = a8;    d1_8 = b8;    d2_8 = c8;    d3_8 = e8;
      e1 = r ? 1'b0 : b1[s];
      exp_q.push_back({e1, model8(r, s, a8, b8, c8, e8)});
   endtask

   task automatic test_reset();
      apply(1'b1, 2'b11, 4'b1111, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
      for (int n = 0; n < 2; n++) begin
         @(posedge clk); #1;
         total++;
         if (exp_q.size() == 0) $display("FAIL reset: scoreboard empty");
         else begin
            exp = exp_q.pop_front();
            if ({y1, y8} !== exp) $display("FAIL reset[%0d]: got %b/%h want %b/%h", n, y1, y8, exp[8], exp[7:0]);
            else passed++;
         end
         if (n == 0) apply(1'b0, 2'b11, 4'b1111, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
      end
   endtask

   task automatic test_select_sweep();
      for (int s = 0; s < 4; s++) begin
         for (int h = 0; h < 2; h++) begin
            apply(1'b0, 2'(s), 4'b0101, 8'hA5, 8'h3C, 8'hF0, 8'h0F);
            @(posedge clk); #1;
            total++;
            exp = exp_q.pop_front();
            if ({y1, y8} !== exp) $display("FAIL sweep s=%0d: got %b/%h want %b/%h", s, y1, y8, exp[8], exp[7:0]);
            else passed++;
         end
      end
   endtask

   task automatic test_one_hot();
      logic [7:0] v[4];
      for (int k = 0; k < 4; k++) begin
         for (int j = 0; j < 4; j++) v[j] = (j == k) ? 8'hFF : 8'h00;
         for (int s = 0; s < 4; s++) begin
            apply(1'b0, 2'(s), 4'(1 << k), v[0], v[1], v[2], v[3]);
            @(posedge clk); #1;
            total++;
            exp = exp_q.pop_front();
            if ({y1, y8} !== exp) $display("FAIL one_hot k=%0d s=%0d: got %b/%h want %b/%h", k, s, y1, y8, exp[8], exp[7:0]);
            else passed++;
         end
      end
   endtask

   task automatic test_latency();
      logic [8:0] prev;
      apply(1'b0, 2'b00, 4'b0001, 8'hA5, 8'h3C, 8'hF0, 8'h0F);
      @(posedge clk); #1;
      total++;
      prev = exp_q.pop_front();
      if ({y1, y8} !== prev) $display("FAIL latency_setup: got %b/%h want %b/%h", y1, y8, prev[8], prev[7:0]);
      else passed++;
      #1;
      apply(1'b0, 2'b11, 4'b0001, 8'hA5, 8'h3C, 8'hF0, 8'h0F);
      #2;
      total++;
      if ({y1, y8} !== prev) $display("FAIL latency_hold: got %b/%h want %b/%h", y1, y8, prev[8], prev[7:0]);
      else passed++;
      @(posedge clk); #1;
      total++;
      exp = exp_q.pop_front();
      if ({y1, y8} !== exp) $display("FAIL latency_update: got %b/%h want %b/%h", y1, y8, exp[8], exp[7:0]);
      else passed++;
   endtask

   task automatic test_mid_reset();
      for (int n = 0; n < 3; n++) begin
         apply(n == 1, 2'b11, 4'b1000, 8'h00, 8'h00, 8'h00, 8'h5A);
         @(posedge clk); #1;
         total++;
         exp = exp_q.pop_front();
         if ({y1, y8} !== exp) $display("FAIL mid_reset[%0d]: got %b/%h want %b/%h", n, y1, y8, exp[8], exp[7:0]);
         else passed++;
      end
   endtask

   task automatic test_x_unselected();
      for (int s = 0; s < 4; s++) begin
         logic [3:0] b1;
         logic [7:0] v[4];
         for (int j = 0; j < 4; j++) begin
            b1[j] = (j == s) ? 1'b1 : ((j % 2 == 0) ? 1'bx : 1'bz);
            v[j]  = (j == s) ? 8'hC3 : ((j % 2 == 0) ? 8'hxx : 8'hzz);
         end
         apply(1'b0, 2'(s), b1, v[0], v[1], v[2], v[3]);
         @(posedge clk); #1;
         total++;
         exp = exp_q.pop_front();
         if ({y1, y8} !== exp) $display("FAIL x_unselected s=%0d: got %b/%h want %b/%h", s, y1, y8, exp[8], exp[7:0]);
         else passed++;
      end
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 24; n++) begin
         apply(($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)), 4'($urandom),
               8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
         @(posedge clk); #1;
         total++;
         exp = exp_q.pop_front();
         if ({y1, y8} !== exp) $display("FAIL back_to_back[%0d]: got %b/%h want %b/%h", n, y1, y8, exp[8], exp[7:0]);
         else passed++;
      end
   endtask

   initial begin
      passed = 0;
      total  = 0;
      test_reset();
      test_select_sweep();
      test_one_hot();
      test_latency();
      test_mid_reset();
      test_x_unselected();
      test_back_to_back();
      total++;
      if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
      else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
